mode_run_sequencer: RTL
=======================

Name: mode_run_sequencer

Overview:
- Synthesizable run controller that drives the MIPS core's reset and mode-select inputs.
- For each of NUM_MODES modes it applies an optional settle gap, then a core reset pulse, then a bounded run window.
- Generalises the fixed two-mode (Sel 0/1) reset-and-run flow to parametrised mode count, select width and durations.
- Adds early termination on halt_req and a captured run length per mode.

Parameters:
- MODE_W, 1: width of sel output.
- NUM_MODES, 2: number of modes sequenced, 0..NUM_MODES-1; must be between 1 and 2**MODE_W.
- PRE_CYCLES, 2: settle cycles before each core reset, with sel already at the new value; 0 allowed.
- RST_CYCLES, 2: cycles cpu_rst is held high per mode; must be at least 1.
- RUN_CYCLES, 165: maximum cycles of each run window; must be at least 1.
- CNT_W, 16: counter width; must satisfy 2**CNT_W > max(PRE_CYCLES, RST_CYCLES, RUN_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset of this block.
- start  input  1  single-cycle request to begin a full sequence.
- halt_req  input  1  core signals program end; terminates the current run window early.
- cpu_rst  output  1  reset to the MIPS core.
- sel  output  MODE_W  mode select to the MIPS core.
- running  output  1  high while in RUN.
- mode_idx  output  MODE_W  mode currently or last sequenced.
- run_len  output  CNT_W  cycle count of the most recently completed run window.
- run_len_vld  output  1  one-cycle pulse when run_len updates.
- done  output  1  high after the last mode completes; held until the next accepted start.

Behaviour:
- Reset values (async, while rst=1): state=IDLE; cpu_rst=0; sel=0; running=0; mode_idx=0; run_len=0; run_len_vld=0; done=0; counter=0.
- All outputs are registered.
- States: IDLE, PRE, RST, RUN, DONE.
- IDLE or DONE with start=1 -> PRE next cycle, or RST if PRE_CYCLES=0.
  - On that edge: sel=0, mode_idx=0, done=0, counter=0.
  - start in any other state is ignored.
- PRE: cpu_rst=0.
  - After exactly PRE_CYCLES cycles in PRE -> RST.
- RST: cpu_rst=1 for exactly RST_CYCLES cycles, then -> RUN.
  - cpu_rst=0 on the edge that enters RUN.
- RUN: running=1; counter counts cycles spent in RUN, first cycle = 1.
  - Exit on the earliest of: halt_req=1 sampled in a RUN cycle, or counter reaching RUN_CYCLES.
  - On the exit edge: run_len = cycles spent in RUN, including the halt cycle; run_len_vld=1 for one cycle; running=0.
  - If halt_req and the RUN_CYCLES limit occur in the same cycle, run_len=RUN_CYCLES; both causes record the same value.
- RUN exit with mode_idx < NUM_MODES-1:
  - mode_idx and sel increment on the same edge.
  - Next state is PRE, or RST if PRE_CYCLES=0.
  - sel therefore changes at least one cycle before cpu_rst rises, even when PRE_CYCLES=0, because the increment coincides with RUN exit.
- RUN exit with mode_idx = NUM_MODES-1 -> DONE.
  - done=1; sel and mode_idx hold their last values.
- halt_req outside RUN is ignored.
- Counter clears on every state transition; no wrap is possible given the CNT_W constraint.
- Async rst mid-sequence: everything returns to reset values immediately, including cpu_rst=0; no partial run_len_vld is issued.
- NUM_MODES=1: a single PRE/RST/RUN pass, then DONE; sel stays 0.

Test Plan:
- Default params, rst pulse, start at cycle 5. Required response:
  - PRE for 2 cycles, cpu_rst high 2 cycles, run 165 cycles with sel=0; run_len=165 with a vld pulse.
  - sel becomes 1, PRE 2, RST 2, run 165; run_len=165.
  - done=1 and held; sel=1.
- halt_req on the 40th RUN cycle of mode 0 -> run_len=40 and vld pulse; mode 1 still runs the full 165; done=1.
- halt_req on RUN cycle 165 (coincides with limit) -> run_len=165, exactly one vld pulse, no extra transition.
- MODE_W=2, NUM_MODES=4, PRE_CYCLES=0, RUN_CYCLES=10 -> sel steps 0,1,2,3.
  - Each sel change is visible one cycle before cpu_rst rises.
  - Four run_len=10 pulses, then done.
- Async rst asserted between clock edges during mode 1 RUN -> cpu_rst=0, sel=0, running=0, done=0 immediately, with no vld pulse.
  - A subsequent start restarts from mode 0.
- start pulses during PRE/RST/RUN are ignored.
  - start while in DONE clears done and restarts.
  - halt_req held high in IDLE has no effect.

Source files
------------

// File: rtl/mode_run_sequencer.sv
// Run controller for the MIPS core. For each mode it selects the mode, waits a settle
// gap, pulses the core reset, then runs a bounded window that halt_req can end early.
module mode_run_sequencer #(
  parameter int unsigned MODE_W     = 1,
  parameter int unsigned NUM_MODES  = 2,
  parameter int unsigned PRE_CYCLES = 2,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned RUN_CYCLES = 165,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  output logic              cpu_rst,
  output logic [MODE_W-1:0] sel,
  output logic              running,
  output logic [MODE_W-1:0] mode_idx,
  output logic [CNT_W-1:0]  run_len,
  output logic              run_len_vld,
  output logic              done
);

  localparam int unsigned PRE_LAST = (PRE_CYCLES > 0) ? PRE_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0]  PRE_END   = CNT_W'(PRE_LAST);
  localparam logic [CNT_W-1:0]  RST_END   = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0]  RUN_END   = CNT_W'(RUN_CYCLES);
  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

  typedef enum logic [2:0] {IDLE, PRE, RST, RUN, DONE} state_t;

  localparam state_t ENTRY = (PRE_CYCLES == 0) ? RST : PRE;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic              cpu_rst_nxt, running_nxt, vld_nxt, done_nxt;
  logic [MODE_W-1:0] sel_nxt, idx_nxt;
  logic [CNT_W-1:0]  len_nxt;

  assign cnt_inc = cnt + CNT_W'(1);

  // RST spends its first cycle with cpu_rst low so a new sel always settles before the
  // core reset rises; cpu_rst is then high for exactly RST_CYCLES cycles.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cpu_rst_nxt = 1'b0;
    running_nxt = 1'b0;
    sel_nxt     = sel;
    idx_nxt     = mode_idx;
    len_nxt     = run_len;
    vld_nxt     = 1'b0;
    done_nxt    = done;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = ENTRY;
          cnt_nxt   = '0;
          sel_nxt   = '0;
          idx_nxt   = '0;
          done_nxt  = 1'b0;
        end
      end
      PRE: begin
        if (cnt == PRE_END) begin
          state_nxt = RST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      RST: begin
        if (cnt == RST_END) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt     = cnt_inc;
          cpu_rst_nxt = 1'b1;
        end
      end
      RUN: begin
        // cnt_inc is the 1-based number of the current RUN cycle
        if (halt_req || (cnt_inc == RUN_END)) begin
          cnt_nxt = '0;
          len_nxt = cnt_inc;
          vld_nxt = 1'b1;
          if (mode_idx == LAST_MODE) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ENTRY;
            idx_nxt   = mode_idx + MODE_W'(1);
            sel_nxt   = sel + MODE_W'(1);
          end
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    running_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cpu_rst     <= 1'b0;
      sel         <= '0;
      running     <= 1'b0;
      mode_idx    <= '0;
      run_len     <= '0;
      run_len_vld <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cpu_rst     <= cpu_rst_nxt;
      sel         <= sel_nxt;
      running     <= running_nxt;
      mode_idx    <= idx_nxt;
      run_len     <= len_nxt;
      run_len_vld <= vld_nxt;
      done        <= done_nxt;
    end
  end

endmodule
